alu_issue_ctrl: RTL and testbench

//  Initiator side of the ALU interface: accepts 9-bit R.O.E instructions over valid/ready and

---
 rtl/alu_issue_ctrl_pkg.sv | 47 ++++
 rtl/alu_issue_ctrl_roe_regfile.sv | 58 +++++
 rtl/alu_issue_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg
//   Shared definitions for the ALU issue controller: R.O.E opcode encoding,
//   the HALT instruction pattern, issue FSM state type and instruction field
//   helpers. Imported by alu_issue_ctrl and roe_regfile.
package alu_issue_ctrl_pkg;

  localparam int IW = 9;   // instruction width
  localparam int FW = 3;   // width of each instruction field

  // Instruction field positions: [8:6]=op, [5:3]=rs/dest, [2:0]=rt
  localparam int OP_LSB = 6;
  localparam int RS_LSB = 3;
  localparam int RT_LSB = 0;

  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_LSW = 3'd2,
    OP_CLR = 3'd3,
    OP_EMK = 3'd4,
    OP_INC = 3'd5,
    OP_ADD = 3'd6,
    OP_SUB = 3'd7
  } op_code_e;

  // CLR with rs=rt=7 is reserved as HALT.
  localparam logic [IW-1:0] HALT_INSTR = 9'b011_111_111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } issue_state_t;

  function automatic op_code_e op_field(input logic [IW-1:0] instr);
    return op_code_e'(instr[OP_LSB +: FW]);
  endfunction

  function automatic logic [FW-1:0] rs_field(input logic [IW-1:0] instr);
    return instr[RS_LSB +: FW];
  endfunction

  function automatic logic [FW-1:0] rt_field(input logic [IW-1:0] instr);
    return instr[RT_LSB +: FW];
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_roe_regfile.sv
// roe_regfile
//   NREGS x DW register file for the R.O.E issue controller.
//   Two asynchronous read ports, one writeback port (from the retiring ALU
//   instruction) and one external load port (memory return path).
//   If both write ports target the same index in one cycle, the writeback
//   port wins. All registers clear on asynchronous active-low reset.
// Ports
//   clk_i, rst_n_i           clock, async active-low reset
//   rd0_addr_i / rd0_data_o  read port 0 (rs operand)
//   rd1_addr_i / rd1_data_o  read port 1 (rt operand)
//   wb_we_i/addr/data        writeback port (priority)
//   ext_we_i/addr/data       external load port
module roe_regfile
  import alu_issue_ctrl_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int DW    = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [AW-1:0] rd0_addr_i,
  output logic [DW-1:0] rd0_data_o,
  input  logic [AW-1:0] rd1_addr_i,
  output logic [DW-1:0] rd1_data_o,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [DW-1:0] wb_data_i,
  input  logic          ext_we_i,
  input  logic [AW-1:0] ext_addr_i,
  input  logic [DW-1:0] ext_data_i
);

  logic [DW-1:0] r_mem [NREGS];
  logic          w_ext_we;

  // Drop the external write when the writeback port hits the same index.
  assign w_ext_we = ext_we_i && !(wb_we_i && (wb_addr_i == ext_addr_i));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_ext_we) begin
        r_mem[ext_addr_i] <= ext_data_i;
      end
      if (wb_we_i) begin
        r_mem[wb_addr_i] <= wb_data_i;
      end
    end
  end

  assign rd0_data_o = r_mem[rd0_addr_i];
  assign rd1_data_o = r_mem[rd1_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Initiator side of the R.O.E ALU interface. Accepts 9-bit instructions over
//   valid/ready, reads operands from an 8x8 register file, presents
//   op/rs/rt and the carry-link flag to the external combinational ALU, then
//   captures result/ov/bnz and writes the result back one cycle later.
//   Owns the ov (shift-out / carry) flag that chains SLL/SRL/ADD/SUB.
//
//   state  | meaning
//   IDLE   | waiting for an instruction, ready=1
//   EXEC   | instruction on alu_* ports, ALU result captured at end of cycle
//   HALTED | HALT retired, no issue until restart_i
//
// Configuration macro
//   ALU_ISSUE_FWD_EN : back-to-back issue with result forwarding into the
//                      operand read. Undefined: strict 2 clk per instruction.
// Ports
//   clk_i, rst_n_i                 clock, async active-low reset
//   instr_i/instr_valid_i/_ready_o instruction handshake
//   alu_op_o/alu_rs_o/alu_rt_o     registered instruction and operands to ALU
//   alu_ov_o                       carry-link flag to ALU
//   alu_result_i/alu_ov_i/bnz_i    ALU outputs
//   reg_we_i/waddr_i/wdata_i       external register load
//   wb_valid_o/addr/data/is_mem_o  retire pulse and its payload
//   bnz_o                          bnz of the last retired instruction
//   halted_o, restart_i            halt status and restart request
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int DW    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [IW-1:0]            instr_i,
  input  logic                     instr_valid_i,
  output logic                     instr_ready_o,
  output logic [IW-1:0]            alu_op_o,
  output logic [DW-1:0]            alu_rs_o,
  output logic [DW-1:0]            alu_rt_o,
  output logic                     alu_ov_o,
  input  logic [DW-1:0]            alu_result_i,
  input  logic                     alu_ov_i,
  input  logic                     alu_bnz_i,
  input  logic                     reg_we_i,
  input  logic [$clog2(NREGS)-1:0] reg_waddr_i,
  input  logic [DW-1:0]            reg_wdata_i,
  output logic                     wb_valid_o,
  output logic [$clog2(NREGS)-1:0] wb_addr_o,
  output logic [DW-1:0]            wb_data_o,
  output logic                     wb_is_mem_o,
  output logic                     bnz_o,
  output logic                     halted_o,
  input  logic                     restart_i
);

  localparam int AW = $clog2(NREGS);

  issue_state_t  r_state;
  issue_state_t  w_state_nxt;
  logic          r_ov_q;

  logic          w_accept;
  logic          w_exec;
  logic          w_halt_inflight;
  logic          w_retire;
  op_code_e      w_op_q;
  logic          w_is_lsw;
  logic          w_is_clr;
  logic          w_wb_we;
  logic [AW-1:0] w_wb_addr;
  logic [DW-1:0] w_wb_data;
  logic          w_ov_nxt;
  logic          w_bnz_nxt;

  logic [AW-1:0] w_rs_idx;
  logic [AW-1:0] w_rt_idx;
  logic [DW-1:0] w_rf_rs;
  logic [DW-1:0] w_rf_rt;
  logic [DW-1:0] w_opnd_rs;
  logic [DW-1:0] w_opnd_rt;

  // In-flight instruction decode (alu_op_o holds the instruction in EXEC)
  assign w_exec          = (r_state == EXEC);
  assign w_halt_inflight = (alu_op_o == HALT_INSTR);
  assign w_retire        = w_exec && !w_halt_inflight;
  assign w_op_q          = op_field(alu_op_o);
  assign w_is_lsw        = (w_op_q == OP_LSW);
  assign w_is_clr        = (w_op_q == OP_CLR);
  assign w_wb_addr       = rs_field(alu_op_o);

  // CLR is forced to zero here so the RF and ov chain clear regardless of
  // what the external ALU returns for it.
  assign w_wb_we   = w_retire && !w_is_lsw;
  assign w_wb_data = w_is_clr ? '0   : alu_result_i;
  assign w_ov_nxt  = w_is_clr ? 1'b0 : alu_ov_i;
  assign w_bnz_nxt = w_is_clr ? 1'b0 : alu_bnz_i;

  assign w_rs_idx = rs_field(instr_i);
  assign w_rt_idx = rt_field(instr_i);
  assign w_accept = instr_valid_i && instr_ready_o;

  roe_regfile #(
    .NREGS (NREGS),
    .DW    (DW),
    .AW    (AW)
  ) u_regfile (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .rd0_addr_i (w_rs_idx),
    .rd0_data_o (w_rf_rs),
    .rd1_addr_i (w_rt_idx),
    .rd1_data_o (w_rf_rt),
    .wb_we_i    (w_wb_we),
    .wb_addr_i  (w_wb_addr),
    .wb_data_i  (w_wb_data),
    .ext_we_i   (reg_we_i),
    .ext_addr_i (reg_waddr_i),
    .ext_data_i (reg_wdata_i)
  );

`ifdef ALU_ISSUE_FWD_EN
  // The RF write for the in-flight instruction lands on the same edge that
  // captures the next operands, so bypass the writeback value when indices
  // match. LSW does not write the RF, which w_wb_we already excludes.
  assign w_opnd_rs = (w_wb_we && (w_rs_idx == w_wb_addr)) ? w_wb_data : w_rf_rs;
  assign w_opnd_rt = (w_wb_we && (w_rt_idx == w_wb_addr)) ? w_wb_data : w_rf_rt;
`else
  assign w_opnd_rs = w_rf_rs;
  assign w_opnd_rt = w_rf_rt;
`endif

  // ov_q updates on the retire edge, which is also the edge the next
  // instruction enters EXEC, so no extra ov forwarding is needed.
  assign alu_ov_o = r_ov_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    instr_ready_o = 1'b0;
    halted_o      = 1'b0;
    unique case (r_state)
      IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) begin
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (w_halt_inflight) begin
          w_state_nxt = HALTED;
        end else begin
`ifdef ALU_ISSUE_FWD_EN
          instr_ready_o = 1'b1;
          w_state_nxt   = instr_valid_i ? EXEC : IDLE;
`else
          w_state_nxt   = IDLE;
`endif
        end
      end
      HALTED: begin
        halted_o = 1'b1;
        if (restart_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Issue registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      alu_op_o <= '0;
      alu_rs_o <= '0;
      alu_rt_o <= '0;
    end else if (w_accept) begin
      alu_op_o <= instr_i;
      alu_rs_o <= w_opnd_rs;
      alu_rt_o <= w_opnd_rt;
    end
  end

  // Retire capture
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ov_q      <= 1'b0;
      bnz_o       <= 1'b0;
      wb_valid_o  <= 1'b0;
      wb_addr_o   <= '0;
      wb_data_o   <= '0;
      wb_is_mem_o <= 1'b0;
    end else begin
      wb_valid_o <= w_retire;
      if (w_retire) begin
        r_ov_q      <= w_ov_nxt;
        bnz_o       <= w_bnz_nxt;
        wb_addr_o   <= w_wb_addr;
        wb_data_o   <= w_wb_data;
        wb_is_mem_o <= w_is_lsw;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam logic [8:0] HALT = 9'b011_111_111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] instr_i;
  logic       instr_valid_i;
  logic       instr_ready_o;
  logic [8:0] alu_op_o;
  logic [7:0] alu_rs_o, alu_rt_o;
  logic       alu_ov_o;
  logic [7:0] alu_result_i;
  logic       alu_ov_i, alu_bnz_i;
  logic       reg_we_i;
  logic [2:0] reg_waddr_i;
  logic [7:0] reg_wdata_i;
  logic       wb_valid_o;
  logic [2:0] wb_addr_o;
  logic [7:0] wb_data_o;
  logic       wb_is_mem_o, bnz_o, halted_o, restart_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural reference state
  logic [7:0] m_rf [8];
  logic       m_ov;
  logic       m_bnz;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .instr_i(instr_i), .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .alu_op_o(alu_op_o), .alu_rs_o(alu_rs_o), .alu_rt_o(alu_rt_o), .alu_ov_o(alu_ov_o),
    .alu_result_i(alu_result_i), .alu_ov_i(alu_ov_i), .alu_bnz_i(alu_bnz_i),
    .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
    .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_is_mem_o(wb_is_mem_o), .bnz_o(bnz_o), .halted_o(halted_o), .restart_i(restart_i)
  );

  // ALU behaviour, returns {ov, result}. Shifts rotate the carry-link in;
  // ADD/SUB use it as carry/borrow in; LSW computes an address.
  function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] s,
                                       input logic [7:0] t, input logic cin);
    int v;
    case (op)
      3'd0: return {s[7], s[6:0], cin};
      3'd1: return {s[0], cin, s[7:1]};
      3'd2: begin v = (int'(s) + int'(t)) % 256; return {cin, 8'(v)}; end
      3'd3: return 9'd0;
      3'd4: return {cin, s & t};
      3'd5: begin v = int'(s) + 1; return {1'(v > 255), 8'(v % 256)}; end
      3'd6: begin v = int'(s) + int'(t) + int'(cin); return {1'(v > 255), 8'(v % 256)}; end
      default: begin
        v = int'(s) - int'(t) - int'(cin);
        return {1'(v < 0), 8'((v + 512) % 256)};
      end
    endcase
  endfunction

  always_comb begin
    {alu_ov_i, alu_result_i} = alu_f(alu_op_o[8:6], alu_rs_o, alu_rt_o, alu_ov_o);
    alu_bnz_i = (alu_result_i != 8'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 8'd0;
    m_ov  = 1'b0;
    m_bnz = 1'b0;
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_we_i = 1'b1; reg_waddr_i = a; reg_wdata_i = d;
    @(negedge clk);
    reg_we_i = 1'b0;
    m_rf[a] = d;
  endtask

  // Model retire of one non-HALT instruction; returns {ov, result}
  function automatic logic [8:0] model_retire(input logic [8:0] ins, input logic [8:0] r);
    if (ins[8:6] != 3'd2) m_rf[ins[5:3]] = r[7:0];
    m_ov  = r[8];
    m_bnz = (r[7:0] != 8'd0);
    return r;
  endfunction

  // Issue one instruction and follow it to retirement.
  // ext_phase: 0 none, 1 ext load on accept cycle, 2 ext load on EXEC cycle.
  task automatic issue(input logic [8:0] ins, input int ext_phase, input logic [2:0] ea,
                       input logic [7:0] ed, output logic [7:0] got_data, output logic got_ov);
    int n;
    logic [8:0] r;
    logic [8:0] dummy;
    n = 0;
    while (instr_ready_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("ready_before_issue", instr_ready_o, 1);
    instr_i = ins; instr_valid_i = 1'b1;
    if (ext_phase == 1) begin reg_we_i = 1'b1; reg_waddr_i = ea; reg_wdata_i = ed; end
    @(negedge clk);
    instr_valid_i = 1'b0; instr_i = 9'($urandom); reg_we_i = 1'b0;
    check("issue_op", alu_op_o, ins);
    check("issue_rs", alu_rs_o, m_rf[ins[5:3]]);
    check("issue_rt", alu_rt_o, m_rf[ins[2:0]]);
    check("issue_ov", alu_ov_o, m_ov);
    check("no_wb_in_exec", wb_valid_o, 0);
`ifndef ALU_ISSUE_FWD_EN
    check("ready_low_in_exec", instr_ready_o, 0);
`endif
    r = alu_f(ins[8:6], m_rf[ins[5:3]], m_rf[ins[2:0]], m_ov);
    if (ext_phase == 1) m_rf[ea] = ed;
    if (ext_phase == 2) begin reg_we_i = 1'b1; reg_waddr_i = ea; reg_wdata_i = ed; end
    @(negedge clk);
    reg_we_i = 1'b0;
    if (ext_phase == 2) m_rf[ea] = ed;
    if (ins == HALT) begin
      check("halt_no_wb", wb_valid_o, 0);
      check("halt_flag", halted_o, 1);
      check("halt_ready", instr_ready_o, 0);
      check("halt_ov_held", alu_ov_o, m_ov);
    end else begin
      dummy = model_retire(ins, r);
      check("wb_valid", wb_valid_o, 1);
      check("wb_addr", wb_addr_o, ins[5:3]);
      check("wb_data", wb_data_o, r[7:0]);
      check("wb_is_mem", wb_is_mem_o, ins[8:6] == 3'd2);
      check("bnz", bnz_o, m_bnz);
      check("ov_after", alu_ov_o, m_ov);
    end
    got_data = wb_data_o;
    got_ov   = alu_ov_o;
  endtask

  typedef struct {
    bit         ld1; logic [2:0] a1; logic [7:0] d1;
    bit         ld2; logic [2:0] a2; logic [7:0] d2;
    logic [8:0] ins;
    logic [7:0] exp_d;
    logic       exp_ov;
    logic       exp_bnz;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] gd;
    logic       gov;
    logic [8:0] ins, r1, r2;

    vecs[0] = '{1, 3'd1, 8'hF0, 1, 3'd2, 8'h20, {3'd6,3'd1,3'd2}, 8'h10, 1, 1};
    vecs[1] = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, {3'd6,3'd1,3'd2}, 8'h31, 0, 1};
    vecs[2] = '{1, 3'd3, 8'h81, 0, 3'd0, 8'h00, {3'd0,3'd3,3'd0}, 8'h02, 1, 1};
    vecs[3] = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, {3'd1,3'd3,3'd0}, 8'h81, 0, 1};
    vecs[4] = '{1, 3'd5, 8'hFF, 0, 3'd0, 8'h00, {3'd5,3'd5,3'd0}, 8'h00, 1, 0};
    vecs[5] = '{1, 3'd6, 8'h10, 1, 3'd7, 8'h20, {3'd7,3'd6,3'd7}, 8'hEF, 1, 1};
    vecs[6] = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, {3'd3,3'd6,3'd0}, 8'h00, 0, 0};
    vecs[7] = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, {3'd2,3'd1,3'd2}, 8'h51, 0, 1};

    rst_n = 1'b0; instr_i = '0; instr_valid_i = 1'b0; reg_we_i = 1'b0;
    reg_waddr_i = '0; reg_wdata_i = '0; restart_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_ready", instr_ready_o, 1);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_halted", halted_o, 0);
    check("rst_bnz", bnz_o, 0);
    check("rst_alu_op", alu_op_o, 0);
    check("rst_alu_rs", alu_rs_o, 0);
    check("rst_alu_ov", alu_ov_o, 0);

    // restart_i outside HALTED is ignored
    restart_i = 1'b1; @(negedge clk); restart_i = 1'b0;
    check("restart_idle_ready", instr_ready_o, 1);
    check("restart_idle_halted", halted_o, 0);

    // Directed table: carry chain, shift chain, INC wrap, SUB borrow, CLR, LSW
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].ld1) load(vecs[i].a1, vecs[i].d1);
      if (vecs[i].ld2) load(vecs[i].a2, vecs[i].d2);
      issue(vecs[i].ins, 0, 3'd0, 8'd0, gd, gov);
      check($sformatf("vec%0d_data", i), gd, vecs[i].exp_d);
      check($sformatf("vec%0d_ov", i), gov, vecs[i].exp_ov);
      check($sformatf("vec%0d_bnz", i), bnz_o, vecs[i].exp_bnz);
    end

    // Ext write to R4 in the same cycle ADD retires to R4: writeback wins
    load(3'd4, 8'h11);
    issue({3'd6,3'd4,3'd3}, 2, 3'd4, 8'h55, gd, gov);
    check("collide_data", gd, 8'h92);
    issue({3'd4,3'd0,3'd4}, 0, 3'd0, 8'd0, gd, gov);
    check("collide_r4", alu_rt_o, 8'h92);

    // Ext write while accepting: operand sees old value
    issue({3'd6,3'd0,3'd3}, 1, 3'd3, 8'hA5, gd, gov);
    issue({3'd4,3'd0,3'd3}, 0, 3'd0, 8'd0, gd, gov);

    // HALT: no writeback, valid ignored, restart returns to IDLE
    issue(HALT, 0, 3'd0, 8'd0, gd, gov);
    instr_i = {3'd5,3'd0,3'd0}; instr_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halted_hold", halted_o, 1);
      check("halted_no_ready", instr_ready_o, 0);
      check("halted_no_wb", wb_valid_o, 0);
      check("halted_no_issue", alu_op_o, HALT);
    end
    instr_valid_i = 1'b0;
    restart_i = 1'b1; @(negedge clk); restart_i = 1'b0;
    check("restart_ready", instr_ready_o, 1);
    check("restart_halted", halted_o, 0);
    issue({3'd5,3'd7,3'd1}, 0, 3'd0, 8'd0, gd, gov);

    // INC r1 followed immediately by ADD r2,r1
    load(3'd1, 8'h7F);
    load(3'd2, 8'h03);
    @(negedge clk);
    instr_i = {3'd5,3'd1,3'd0}; instr_valid_i = 1'b1;
    r1 = alu_f(3'd5, m_rf[1], m_rf[0], m_ov);
    @(negedge clk);
`ifdef ALU_ISSUE_FWD_EN
    check("fwd_ready_exec", instr_ready_o, 1);
    instr_i = {3'd6,3'd2,3'd1};
    @(negedge clk);
    instr_valid_i = 1'b0;
    check("fwd_wb1_valid", wb_valid_o, 1);
    check("fwd_wb1_data", wb_data_o, r1[7:0]);
    check("fwd_rt_forwarded", alu_rt_o, r1[7:0]);
    check("fwd_rs", alu_rs_o, m_rf[2]);
    check("fwd_ov_link", alu_ov_o, r1[8]);
    ins = model_retire({3'd5,3'd1,3'd0}, r1);
    r2 = alu_f(3'd6, m_rf[2], m_rf[1], m_ov);
    @(negedge clk);
    check("fwd_wb2_valid", wb_valid_o, 1);
    check("fwd_wb2_data", wb_data_o, r2[7:0]);
    check("fwd_wb2_addr", wb_addr_o, 2);
    ins = model_retire({3'd6,3'd2,3'd1}, r2);
    @(negedge clk);
    check("fwd_wb_idle", wb_valid_o, 0);
`else
    check("strict_ready_exec", instr_ready_o, 0);
    instr_i = {3'd6,3'd2,3'd1};
    @(negedge clk);
    check("strict_wb1_valid", wb_valid_o, 1);
    check("strict_wb1_data", wb_data_o, r1[7:0]);
    check("strict_not_taken", alu_op_o, {3'd5,3'd1,3'd0});
    ins = model_retire({3'd5,3'd1,3'd0}, r1);
    r2 = alu_f(3'd6, m_rf[2], m_rf[1], m_ov);
    @(negedge clk);
    instr_valid_i = 1'b0;
    check("strict_op2", alu_op_o, {3'd6,3'd2,3'd1});
    check("strict_rt_new", alu_rt_o, m_rf[1]);
    check("strict_gap", wb_valid_o, 0);
    @(negedge clk);
    check("strict_wb2_valid", wb_valid_o, 1);
    check("strict_wb2_data", wb_data_o, r2[7:0]);
    ins = model_retire({3'd6,3'd2,3'd1}, r2);
`endif

    // Random traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        load(3'($urandom), 8'($urandom));
      end else begin
        ins = 9'($urandom);
        if (ins == HALT) ins[0] = 1'b0;
        issue(ins, int'($urandom_range(0, 2)), 3'($urandom), 8'($urandom), gd, gov);
      end
    end

    // Reset during EXEC: instruction dropped, RF cleared
    load(3'd1, 8'h12);
    load(3'd2, 8'h34);
    @(negedge clk);
    instr_i = {3'd6,3'd1,3'd2}; instr_valid_i = 1'b1;
    @(negedge clk);
    instr_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_wb", wb_valid_o, 0);
    check("midrst_ready", instr_ready_o, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midrst_no_wb", wb_valid_o, 0);
      check("midrst_ready_after", instr_ready_o, 1);
    end
    issue({3'd6,3'd1,3'd2}, 0, 3'd0, 8'd0, gd, gov);
    check("midrst_rf_cleared", gd, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
